// File: rtl/seven_seg_pkg.sv
// Shared widths and segment patterns for the 7-segment scan controller.
// Segment order is {a,b,c,d,e,f,g}, active-high.
package seven_seg_pkg;

  localparam int DIGIT_W = 4;
  localparam int SEG_W   = 7;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0000001;

  localparam logic [SEG_W-1:0] GLYPH_0 = 7'b1111110;
  localparam logic [SEG_W-1:0] GLYPH_1 = 7'b0110000;
  localparam logic [SEG_W-1:0] GLYPH_2 = 7'b1101101;
  localparam logic [SEG_W-1:0] GLYPH_3 = 7'b1111001;
  localparam logic [SEG_W-1:0] GLYPH_4 = 7'b0110011;
  localparam logic [SEG_W-1:0] GLYPH_5 = 7'b1011011;
  localparam logic [SEG_W-1:0] GLYPH_6 = 7'b1011111;
  localparam logic [SEG_W-1:0] GLYPH_7 = 7'b1110000;
  localparam logic [SEG_W-1:0] GLYPH_8 = 7'b1111111;
  localparam logic [SEG_W-1:0] GLYPH_9 = 7'b1111011;

endpackage

// File: rtl/_7_seg_display.sv
// Combinational BCD-to-segment decoder shared by every digit slot.
// Non-decimal nibbles show a dash so corrupted values stay visible.
module _7_seg_display
  import seven_seg_pkg::*;
(
  input  logic [DIGIT_W-1:0] bcd,
  output logic [SEG_W-1:0]   seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = GLYPH_0;
      4'd1: seg = GLYPH_1;
      4'd2: seg = GLYPH_2;
      4'd3: seg = GLYPH_3;
      4'd4: seg = GLYPH_4;
      4'd5: seg = GLYPH_5;
      4'd6: seg = GLYPH_6;
      4'd7: seg = GLYPH_7;
      4'd8: seg = GLYPH_8;
      4'd9: seg = GLYPH_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed N-digit 7-segment scan controller with ghost blanking,
// leading-zero suppression and a frame-synchronous load handshake.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int REFRESH_DIV      = 50000,
  parameter int BLANK_CYCLES     = 2,
  parameter int ACTIVE_LOW_DIGIT = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] load_value,
  input  logic                          lzs_en,
  output logic [SEG_W-1:0]              seg,
  output logic [NUM_DIGITS-1:0]         digit_en,
  output logic                          frame_done
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] DIGIT_OFF = (ACTIVE_LOW_DIGIT != 0) ? '1 : '0;

  logic [DIV_W-1:0]              div_cnt;
  logic [IDX_W-1:0]              digit_idx;
  logic [DIGIT_W*NUM_DIGITS-1:0] disp_reg;
  logic [DIGIT_W*NUM_DIGITS-1:0] pend_reg;
  logic                          pending;
  logic                          ready_q;

  logic                  slot_end;
  logic                  frame_end;
  logic                  transfer;
  logic [DIGIT_W-1:0]    cur_nibble;
  logic [SEG_W-1:0]      dec_seg;
  logic [NUM_DIGITS-1:0] lead_zero;
  logic                  zero_run;
  logic                  suppress;
  logic [NUM_DIGITS-1:0] active_mask;
  logic [NUM_DIGITS-1:0] digit_on;

  // ready_q holds load_ready low for the first cycle after reset release
  assign load_ready = ready_q && !pending;
  assign transfer   = load_valid && load_ready;
  assign slot_end   = (div_cnt == DIV_W'(REFRESH_DIV - 1));
  assign frame_end  = slot_end && (digit_idx == IDX_W'(NUM_DIGITS - 1));

  assign cur_nibble = disp_reg[int'(digit_idx)*DIGIT_W +: DIGIT_W];

  _7_seg_display u_decoder (
    .bcd (cur_nibble),
    .seg (dec_seg)
  );

  // lead_zero[k] is set when digit k and every digit above it are zero
  always_comb begin
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      zero_run     = zero_run && (disp_reg[k*DIGIT_W +: DIGIT_W] == '0);
      lead_zero[k] = zero_run;
    end
  end

  assign suppress    = lzs_en && lead_zero[digit_idx];
  assign active_mask = NUM_DIGITS'(1) << digit_idx;
  assign digit_on    = (ACTIVE_LOW_DIGIT != 0) ? ~active_mask : active_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      digit_idx  <= '0;
      disp_reg   <= '0;
      pend_reg   <= '0;
      pending    <= 1'b0;
      ready_q    <= 1'b0;
      seg        <= SEG_BLANK;
      digit_en   <= DIGIT_OFF;
      frame_done <= 1'b0;
    end else begin
      ready_q <= 1'b1;

      if (slot_end) begin
        div_cnt   <= '0;
        digit_idx <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      // commit and accept are exclusive: one needs pending set, the other clear
      frame_done <= frame_end && pending;
      if (frame_end && pending) begin
        disp_reg <= pend_reg;
        pending  <= 1'b0;
      end else if (transfer) begin
        pend_reg <= load_value;
        pending  <= 1'b1;
      end

      if (int'(div_cnt) < BLANK_CYCLES) begin
        seg      <= SEG_BLANK;
        digit_en <= DIGIT_OFF;
      end else begin
        seg      <= suppress ? SEG_BLANK : dec_seg;
        digit_en <= digit_on;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Randomized self-checking bench for seven_seg_scan_ctrl against a frame-position
// model: the expected display is derived from the cycle count since reset release.
module tb_seven_seg_scan_ctrl;

  localparam int N = 4;
  localparam int R = 4;
  localparam int B = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_value;
  logic        lzs_en;
  logic [6:0]  seg;
  logic [3:0]  digit_en;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  logic [6:0] glyph_tab [0:15] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011,
    7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001
  };

  int unsigned m_pos;
  logic [15:0] m_disp;
  logic [15:0] m_pend;
  bit          m_pending;
  logic [15:0] offers[$];
  bit          rand_lzs;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS       (N),
    .REFRESH_DIV      (R),
    .BLANK_CYCLES     (B),
    .ACTIVE_LOW_DIGIT (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .lzs_en     (lzs_en),
    .seg        (seg),
    .digit_en   (digit_en),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // One clock: drive inputs, predict this edge from the frame position, compare after the edge
  task automatic applyStimulus(input bit do_rst);
    int          cnt, idx;
    logic [6:0]  e_seg;
    logic [3:0]  e_den;
    bit          e_fd, ready, boundary, accepted;
    logic [15:0] upper;

    rst = do_rst;
    if (do_rst) load_valid = 1'b0;
    else if (!load_valid && offers.size() > 0 && $urandom_range(0, 3) == 0) begin
      load_value = offers.pop_front();
      load_valid = 1'b1;
    end
    if (rand_lzs && $urandom_range(0, 40) == 0) lzs_en = ~lzs_en;

    accepted = 1'b0;
    if (do_rst) begin
      e_seg = 7'b0; e_den = 4'hF; e_fd = 1'b0;
      m_pos = 0; m_disp = '0; m_pend = '0; m_pending = 1'b0;
    end else begin
      cnt      = int'(m_pos % R);
      idx      = int'((m_pos / R) % N);
      ready    = (m_pos >= 1) && !m_pending;
      boundary = (m_pos % (R * N)) == (R * N - 1);
      upper    = m_disp >> (4 * idx);
      if (cnt < B) begin
        e_seg = 7'b0; e_den = 4'hF;
      end else begin
        e_seg = (lzs_en && idx > 0 && upper == 16'h0) ? 7'b0 : glyph_tab[upper[3:0]];
        e_den = ~(4'b0001 << idx);
      end
      e_fd = boundary && m_pending;
      if (e_fd) begin
        m_disp    = m_pend;
        m_pending = 1'b0;
      end else if (load_valid && ready) begin
        m_pend    = load_value;
        m_pending = 1'b1;
        accepted  = 1'b1;
      end
      m_pos++;
    end

    @(posedge clk);
    #1;
    checkOutput("seg", 32'(seg), 32'(e_seg));
    checkOutput("digit_en", 32'(digit_en), 32'(e_den));
    checkOutput("frame_done", 32'(frame_done), 32'(e_fd));
    checkOutput("load_ready", 32'(load_ready), do_rst ? 32'd0 : 32'(!m_pending));
    if (accepted) load_valid = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    load_value = '0;
    lzs_en     = 1'b0;
    rand_lzs   = 1'b0;

    $display("[TB] reset and plain-value loads");
    repeat (3) applyStimulus(1'b1);
    offers = '{16'h1234, 16'h1111, 16'h2222};
    repeat (160) applyStimulus(1'b0);

    $display("[TB] leading-zero suppression");
    lzs_en = 1'b1;
    offers = '{16'h0070, 16'h0000, 16'h00A5};
    repeat (160) applyStimulus(1'b0);

    $display("[TB] reset with a value pending");
    lzs_en = 1'b0;
    offers.push_back(16'h9876);
    for (int i = 0; i < 100 && !m_pending; i++) applyStimulus(1'b0);
    checkOutput("pend_ready", 32'(load_ready), 32'd0);
    repeat (2) applyStimulus(1'b1);
    repeat (40) applyStimulus(1'b0);

    $display("[TB] randomized traffic");
    rand_lzs = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (offers.size() == 0) offers.push_back(16'($urandom) >> (4 * $urandom_range(0, 3)));
      applyStimulus($urandom_range(0, 299) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
